// File: rtl/sdes_round_sequencer_if.sv
// Handshake bundle for the S-DES round sequencer: block/key in, ciphertext out.
// Vectors are [7:0]/[5:0]; S-DES "bit 0" (the MSB) is the top bit of each vector.
interface sdes_round_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_block;
    logic [5:0] in_key;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/sdes_round_sequencer.sv
// Iterative S-DES Feistel round sequencer: latches a block and key, applies ROUNDS
// rounds (one per clock) with a rotating subkey, then holds the ciphertext until taken.
module sdes_round_sequencer #(
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sdes_round_sequencer_if.slave bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      round_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // DES S1, row-major: index = {row, column}
    localparam logic [3:0] S1 [64] = '{
        4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
        4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
        4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
        4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13
    };

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    state_t           state;
    state_t           state_nx;
    logic [7:0]       block_reg;
    logic [5:0]       key_reg;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_round;

    // Spec bit i of an n-bit field is vector bit n-1-i, hence the reversed picks below.
    function automatic logic [7:0] round_f(input logic [7:0] b, input logic [5:0] k);
        logic [3:0] l;
        logic [3:0] r;
        logic [3:0] o;
        logic [3:0] p;
        logic [5:0] e;
        logic [5:0] s;
        l = b[7:4];
        r = b[3:0];
        e = {r[3], r[0], r[2], r[1], r[3], r[2]};
        s = e ^ k;
        o = S1[{s[5], s[0], s[4:1]}];
        p = {o[1], o[3], o[2], o[0]};
        return {r, p ^ l};
    endfunction

    assign accept     = bus.in_valid && (state == IDLE);
    assign last_round = (cnt == LAST);
    assign round_idx  = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_block = '0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_round) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_block = block_reg;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The key register is rotated one place per round, so round i sees key <<< (i mod 6)
    // without a modulo; the counter is parked at 0 whenever RUN is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_reg <= '0;
            key_reg   <= '0;
            cnt       <= '0;
        end else if (accept) begin
            block_reg <= bus.in_block;
            key_reg   <= bus.in_key;
            cnt       <= '0;
        end else if (state == RUN) begin
            block_reg <= round_f(block_reg, key_reg);
            key_reg   <= {key_reg[4:0], key_reg[5]};
            cnt       <= last_round ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sdes_round_sequencer.sv
// Self-checking bench for sdes_round_sequencer: directed steps plus a randomized
// scoreboard run against an arithmetic model of the S-DES round schedule.
module tb_sdes_round_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_block;
    logic [5:0]  in_key;
    int unsigned sel;

    int n_tests = 0;
    int n_fail  = 0;

    sdes_round_sequencer_if if_r1 ();
    sdes_round_sequencer_if if_r2 ();
    sdes_round_sequencer_if if_r7 ();

    logic       busy1, busy2, busy7;
    logic [3:0] ri1, ri2, ri7;

    assign if_r1.in_valid  = in_valid && (sel == 1);
    assign if_r2.in_valid  = in_valid && (sel == 2);
    assign if_r7.in_valid  = in_valid && (sel == 7);
    assign if_r1.in_block  = in_block;
    assign if_r2.in_block  = in_block;
    assign if_r7.in_block  = in_block;
    assign if_r1.in_key    = in_key;
    assign if_r2.in_key    = in_key;
    assign if_r7.in_key    = in_key;
    assign if_r1.out_ready = out_ready;
    assign if_r2.out_ready = out_ready;
    assign if_r7.out_ready = out_ready;

    sdes_round_sequencer #(.ROUNDS(1), .CNT_W(4)) u_r1 (
        .clk(clk), .rst(rst), .bus(if_r1.slave), .busy(busy1), .round_idx(ri1));
    sdes_round_sequencer #(.ROUNDS(2), .CNT_W(4)) u_r2 (
        .clk(clk), .rst(rst), .bus(if_r2.slave), .busy(busy2), .round_idx(ri2));
    sdes_round_sequencer #(.ROUNDS(7), .CNT_W(4)) u_r7 (
        .clk(clk), .rst(rst), .bus(if_r7.slave), .busy(busy7), .round_idx(ri7));

    logic       m_in_ready, m_out_valid, m_busy;
    logic [7:0] m_out_block;
    logic [3:0] m_round_idx;

    always_comb begin
        m_in_ready  = if_r7.in_ready;
        m_out_valid = if_r7.out_valid;
        m_out_block = if_r7.out_block;
        m_busy      = busy7;
        m_round_idx = ri7;
        if (sel == 1) begin
            m_in_ready  = if_r1.in_ready;
            m_out_valid = if_r1.out_valid;
            m_out_block = if_r1.out_block;
            m_busy      = busy1;
            m_round_idx = ri1;
        end else if (sel == 2) begin
            m_in_ready  = if_r2.in_ready;
            m_out_valid = if_r2.out_valid;
            m_out_block = if_r2.out_block;
            m_busy      = busy2;
            m_round_idx = ri2;
        end
    end

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (spec bit 0 = MSB) ----------------
    int s1_tab[4][16] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
        '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
        '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
        '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
    };

    function automatic int bit_at(input int x, input int i, input int w);
        return (x >> (w - 1 - i)) & 1;
    endfunction

    function automatic int ref_f(input int b, input int k);
        int e_pick[6] = '{0, 3, 1, 2, 0, 1};
        int l, r, e, s, o, p;
        l = (b >> 4) & 15;
        r = b & 15;
        e = 0;
        for (int j = 0; j < 6; j++) e = e * 2 + bit_at(r, e_pick[j], 4);
        s = e ^ k;
        o = s1_tab[bit_at(s, 0, 6) * 2 + bit_at(s, 5, 6)][(s >> 1) & 15];
        p = bit_at(o, 2, 4) * 8 + bit_at(o, 0, 4) * 4 + bit_at(o, 1, 4) * 2 + bit_at(o, 3, 4);
        return r * 16 + (p ^ l);
    endfunction

    function automatic int subkey(input int k, input int i);
        int n;
        n = i % 6;
        return ((k << n) | (k >> (6 - n))) & 63;
    endfunction

    function automatic logic [7:0] cipher(input logic [7:0] b, input logic [5:0] k, input int rounds);
        int x;
        x = int'(b);
        for (int i = 0; i < rounds; i++) x = ref_f(x, subkey(int'(k), i));
        return 8'(x);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int nblk, input int rounds, input bit rnd_hs);
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int acc = 0;
        int done = 0;
        int cyc = 0;
        int last_acc = -1;
        while (done < nblk && cyc < 40 * nblk + 100) begin
            in_valid  = (acc < nblk) && (rnd_hs ? ($urandom_range(0, 1) == 1) : 1'b1);
            out_ready = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_block  = 8'($urandom);
            in_key    = 6'($urandom);
            #1;
            if (in_valid && m_in_ready) begin
                q.push_back(cipher(in_block, in_key, rounds));
                if (!rnd_hs && last_acc >= 0) check("stream_spacing", cyc - last_acc, rounds + 2);
                last_acc = cyc;
                acc++;
            end
            if (m_out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_spurious", m_out_valid, 0);
                end else begin
                    exp_b = q.pop_front();
                    check("stream_block", m_out_block, exp_b);
                end
                done++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", done, nblk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] exp_b;
        int sels[3] = '{1, 2, 7};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = '0; in_key = '0; sel = 2;
        #3;
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            #1;
            check("rst_in_ready", m_in_ready, 1);
            check("rst_out_valid", m_out_valid, 0);
            check("rst_busy", m_busy, 0);
            check("rst_out_block", m_out_block, 0);
            check("rst_round_idx", m_round_idx, 0);
        end
        step();
        step();
        rst = 1'b0;

        // ROUNDS=1 vector
        sel = 1; out_ready = 1'b1; in_block = 8'h56; in_key = 6'b101100; in_valid = 1'b1;
        #1;
        check("r1_ready", m_in_ready, 1);
        step(); in_valid = 1'b0;
        check("r1_busy", m_busy, 1);
        check("r1_run_ready", m_in_ready, 0);
        step();
        check("r1_valid", m_out_valid, 1);
        check("r1_block", m_out_block, 8'h6A);
        step();
        check("r1_done_once", m_out_valid, 0);
        check("r1_idle_ready", m_in_ready, 1);

        // ROUNDS=2 with inputs churning during RUN
        sel = 2; in_block = 8'h56; in_key = 6'b101100; in_valid = 1'b1;
        #1;
        step(); in_valid = 1'b0; in_block = 8'($urandom); in_key = 6'($urandom);
        check("r2_busy0", m_busy, 1);
        check("r2_idx0", m_round_idx, 0);
        step(); in_block = 8'($urandom); in_key = 6'($urandom);
        check("r2_busy1", m_busy, 1);
        check("r2_idx1", m_round_idx, 1);
        step();
        check("r2_busy_done", m_busy, 0);
        check("r2_valid", m_out_valid, 1);
        check("r2_block", m_out_block, 8'hA1);
        check("r2_idx_done", m_round_idx, 0);
        step();
        check("r2_done_once", m_out_valid, 0);
        check("r2_idle_ready", m_in_ready, 1);

        // backpressure
        out_ready = 1'b0; in_block = 8'h56; in_key = 6'b101100; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_block = 8'hFF;
            check("bp_valid", m_out_valid, 1);
            check("bp_block", m_out_block, 8'hA1);
            check("bp_ready", m_in_ready, 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_valid_last", m_out_valid, 1);
        step(); out_ready = 1'b0;
        check("bp_after_valid", m_out_valid, 0);
        check("bp_after_ready", m_in_ready, 1);

        // async reset mid-RUN
        out_ready = 1'b1; in_block = 8'h56; in_key = 6'b101100; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rr_out_valid", m_out_valid, 0);
        check("rr_in_ready", m_in_ready, 1);
        check("rr_busy", m_busy, 0);
        check("rr_out_block", m_out_block, 0);
        check("rr_round_idx", m_round_idx, 0);
        step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rr_no_output", m_out_valid, 0);
            step();
        end

        // async reset mid-DONE
        out_ready = 1'b0; in_block = 8'h56; in_key = 6'b101100; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step();
        step();
        check("rd_valid_before", m_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rd_out_valid", m_out_valid, 0);
        check("rd_out_block", m_out_block, 0);
        check("rd_in_ready", m_in_ready, 1);
        step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rd_no_output", m_out_valid, 0);
            step();
        end

        // fresh block after reset
        in_block = 8'($urandom); in_key = 6'($urandom); in_valid = 1'b1;
        exp_b = cipher(in_block, in_key, 2);
        step(); in_valid = 1'b0;
        step();
        step();
        check("fresh_valid", m_out_valid, 1);
        check("fresh_block", m_out_block, exp_b);
        out_ready = 1'b1;
        step(); out_ready = 1'b0;

        // back-to-back, in_valid and out_ready held high
        sel = 1; #1;
        run_stream(20, 1, 1'b0);
        sel = 2; #1;
        run_stream(20, 2, 1'b0);

        // random regression, ROUNDS=7 wraps the 6-step key rotation
        sel = 7; #1;
        run_stream(1000, 7, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdes_round_sequencer.md
Name: sdes_round_sequencer

Overview:
Iterative controller for the 8-bit Feistel round datapath: expansion, 6-bit key XOR, S1 substitution, 4-bit permutation, and left-half XOR. It accepts a block and a 6-bit master key over a valid/ready handshake. It then runs ROUNDS rounds, one per clock, deriving each round's subkey by rotation. The ciphertext is returned over a valid/ready output handshake, and the block sits between the host-side block source and the cipher result sink.

Parameters:
ROUNDS, 4, number of Feistel rounds per block; legal range 1..15.
CNT_W, 4, width of round counter; must satisfy 2^CNT_W > ROUNDS.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  block/key offered
in_ready  output  1  sequencer can accept a block
in_block  input  8  plaintext, bit 0 = MSB; [0:3] = L, [4:7] = R
in_key  input  6  master key, bit 0 = MSB
out_valid  output  1  ciphertext available
out_ready  input  1  sink accepts ciphertext
out_block  output  8  ciphertext
busy  output  1  high while rounds are executing
round_idx  output  CNT_W  index of the round applied at the next edge; 0 outside RUN

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; out_block=0; round_idx=0.
  - Internal block and key registers are cleared.
- Round function F(block, k), purely combinational, one instance:
  - L=block[0:3], R=block[4:7].
  - E={R[0],R[3],R[1],R[2],R[0],R[1]}; s=E^k.
  - S1 lookup: row={s[0],s[5]}, column=s[1:4]. Use the standard DES S1 table, giving a 4-bit value o.
  - P={o[2],o[0],o[1],o[3]}.
  - Result is {R, P^L}. No final swap after the last round.
- Subkey for round i = in_key rotated left by (i mod 6) positions, with bit 0 as MSB. Round 0 uses the key unmodified.
- FSM:
  - IDLE:
    - in_ready=1.
    - On an edge with in_valid&in_ready: latch in_block and in_key, round_idx=0, go to RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Each edge: block_reg<=F(block_reg, subkey(round_idx)).
    - If round_idx==ROUNDS-1: go to DONE, otherwise round_idx increments.
  - DONE:
    - out_valid=1, out_block=block_reg, busy=0, in_ready=0.
    - On an edge with out_ready: go to IDLE, out_valid=0.
    - out_block holds its value, stable, until the handshake completes.
- Latency: acceptance edge N → out_valid high after edge N+ROUNDS. Throughput is one block per ROUNDS+2 cycles minimum.
- Boundary conditions:
  - in_valid while not in IDLE: ignored; no input is sampled.
  - in_block/in_key changing after acceptance: no effect, since the values are latched.
  - out_ready high outside DONE: ignored.
  - out_ready held high continuously: DONE lasts exactly one cycle.
  - ROUNDS=1: RUN lasts one cycle.
  - Reset mid-RUN or mid-DONE: immediate return to reset values; the block in flight is discarded; no out_valid is produced for it.
  - Deassertion of reset: the next edge may accept a block.
- All registers are updated on the rising edge of clk only, except for the reset behaviour above.

Test Plan:
- ROUNDS=1, in_block=8'b01010110, in_key=6'b101100, out_ready=1 → out_valid one edge after acceptance, out_block=8'b01101010 (0x6A).
- ROUNDS=2, same stimulus → round 0 intermediate is 0x6A; round 1 uses subkey 6'b011001 (s=111111, S1 output 1101); out_block=8'b10100001 (0xA1) after 2 edges.
- Backpressure, ROUNDS=2: out_ready=0 for 5 cycles after out_valid.
  - Expected: out_block holds 0xA1, in_ready stays 0, and a new in_valid is ignored.
  - Then out_ready=1: one handshake, after which in_ready=1 the following cycle.
- Input changes during RUN: change in_block/in_key every cycle after acceptance → result is still 0xA1. busy is high for exactly ROUNDS cycles, and round_idx steps 0→1.
- Async reset asserted mid-RUN (between clock edges):
  - Expected: out_valid=0, in_ready=1, busy=0 and out_block=0 immediately, with no output for the aborted block.
  - Then a fresh block gives the correct result.
- Back-to-back blocks with in_valid held high and out_ready=1 → each block is accepted only in IDLE, and results come out in order.
  - Random regression: 1000 blocks checked against a reference model of F with the rotating subkey schedule.
